alu: RTL and testbench

Registered 32-bit MIPS-subset arithmetic/logic unit. Decodes a 32-bit MIPS instruction word, selects operands from two input data registers (regA, regB) via the rs/rt fields, computes the result and zero/negative/overflow flags, and registers them for the execute stage.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_if.sv | 28 ++
 rtl/alu_core.sv | 133 +++++++++++++
 rtl/alu.sv | 45 ++++
 tb/tb_alu.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Purpose  : Opcodes, function codes, flag indices and overflow helpers
//            shared by the ALU datapath and its interface.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   localparam int unsigned c_data_w = 32;
   localparam int unsigned c_flag_w = 3;

   localparam int unsigned c_flag_zero = 2;
   localparam int unsigned c_flag_neg  = 1;
   localparam int unsigned c_flag_ovf  = 0;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_addiu = 6'b001001;
   localparam logic [5:0] c_op_slti  = 6'b001010;
   localparam logic [5:0] c_op_sltiu = 6'b001011;
   localparam logic [5:0] c_op_andi  = 6'b001100;
   localparam logic [5:0] c_op_ori   = 6'b001101;
   localparam logic [5:0] c_op_xori  = 6'b001110;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;

   localparam logic [5:0] c_fn_sll  = 6'b000000;
   localparam logic [5:0] c_fn_srl  = 6'b000010;
   localparam logic [5:0] c_fn_sra  = 6'b000011;
   localparam logic [5:0] c_fn_sllv = 6'b000100;
   localparam logic [5:0] c_fn_srlv = 6'b000110;
   localparam logic [5:0] c_fn_srav = 6'b000111;
   localparam logic [5:0] c_fn_add  = 6'b100000;
   localparam logic [5:0] c_fn_addu = 6'b100001;
   localparam logic [5:0] c_fn_sub  = 6'b100010;
   localparam logic [5:0] c_fn_subu = 6'b100011;
   localparam logic [5:0] c_fn_and  = 6'b100100;
   localparam logic [5:0] c_fn_or   = 6'b100101;
   localparam logic [5:0] c_fn_xor  = 6'b100110;
   localparam logic [5:0] c_fn_nor  = 6'b100111;
   localparam logic [5:0] c_fn_slt  = 6'b101010;
   localparam logic [5:0] c_fn_sltu = 6'b101011;

   // Signed overflow detected from sign bits only.
   function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] s);
      return (a[31] == b[31]) && (s[31] != a[31]);
   endfunction

   function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] d);
      return (a[31] != b[31]) && (d[31] != a[31]);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
//------------------------------------------------------------------------------
// Module   : alu_if
// Purpose  : Instruction/operand inputs and registered result/flag outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_if;
   import alu_pkg::*;

   logic [c_data_w-1:0] instruction;
   logic [c_data_w-1:0] regA;
   logic [c_data_w-1:0] regB;
   logic [c_data_w-1:0] result;
   logic [c_flag_w-1:0] flags;

   modport master (
      output instruction, regA, regB,
      input  result, flags
   );

   modport slave (
      input  instruction, regA, regB,
      output result, flags
   );
endinterface

`default_nettype wire

// File: rtl/alu_core.sv
//------------------------------------------------------------------------------
// Module   : alu_core
// Purpose  : Combinational MIPS-subset decode/execute producing next result
//            and zero/negative/overflow flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_core
   import alu_pkg::*;
(
   input  wire logic [c_data_w-1:0] i_instruction,
   input  wire logic [c_data_w-1:0] i_reg_a,
   input  wire logic [c_data_w-1:0] i_reg_b,
   output logic      [c_data_w-1:0] o_result,
   output logic      [c_flag_w-1:0] o_flags
);

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_shamt;
   logic [31:0] w_rs_val;
   logic [31:0] w_rt_val;
   logic [31:0] w_simm;
   logic [31:0] w_zimm;
   logic [31:0] w_res;
   logic        w_neg;
   logic        w_ovf;
   logic        w_valid;

   assign w_op     = i_instruction[31:26];
   assign w_rs     = i_instruction[25:21];
   assign w_rt     = i_instruction[20:16];
   assign w_shamt  = i_instruction[10:6];
   assign w_funct  = i_instruction[5:0];
   assign w_simm   = {{16{i_instruction[15]}}, i_instruction[15:0]};
   assign w_zimm   = {16'h0000, i_instruction[15:0]};

   // Only two registers exist: address 0 is regA, everything else is regB.
   assign w_rs_val = (w_rs == 5'd0) ? i_reg_a : i_reg_b;
   assign w_rt_val = (w_rt == 5'd0) ? i_reg_a : i_reg_b;

   always_comb begin
      w_res   = '0;
      w_neg   = 1'b0;
      w_ovf   = 1'b0;
      w_valid = 1'b1;
      case (w_op)
         c_op_rtype: begin
            case (w_funct)
               c_fn_add: begin
                  w_res = w_rs_val + w_rt_val;
                  w_neg = w_res[31];
                  w_ovf = add_ovf(w_rs_val, w_rt_val, w_res);
               end
               c_fn_addu: begin
                  w_res = w_rs_val + w_rt_val;
                  w_neg = w_res[31];
               end
               c_fn_sub: begin
                  w_res = w_rs_val - w_rt_val;
                  w_neg = w_res[31];
                  w_ovf = sub_ovf(w_rs_val, w_rt_val, w_res);
               end
               c_fn_subu: begin
                  w_res = w_rs_val - w_rt_val;
                  w_neg = w_res[31];
               end
               c_fn_and:  w_res = w_rs_val & w_rt_val;
               c_fn_or:   w_res = w_rs_val | w_rt_val;
               c_fn_xor:  w_res = w_rs_val ^ w_rt_val;
               c_fn_nor:  w_res = ~(w_rs_val | w_rt_val);
               c_fn_slt: begin
                  w_neg = $signed(w_rs_val) < $signed(w_rt_val);
                  w_res = {31'd0, w_neg};
               end
               c_fn_sltu: begin
                  w_neg = w_rs_val < w_rt_val;
                  w_res = {31'd0, w_neg};
               end
               c_fn_sll:  w_res = w_rt_val << w_shamt;
               c_fn_srl:  w_res = w_rt_val >> w_shamt;
               c_fn_sra:  w_res = $unsigned($signed(w_rt_val) >>> w_shamt);
               c_fn_sllv: w_res = w_rt_val << w_rs_val[4:0];
               c_fn_srlv: w_res = w_rt_val >> w_rs_val[4:0];
               c_fn_srav: w_res = $unsigned($signed(w_rt_val) >>> w_rs_val[4:0]);
               default:   w_valid = 1'b0;
            endcase
         end
         c_op_addi: begin
            w_res = w_rs_val + w_simm;
            w_neg = w_res[31];
            w_ovf = add_ovf(w_rs_val, w_simm, w_res);
         end
         c_op_addiu, c_op_lw, c_op_sw: begin
            w_res = w_rs_val + w_simm;
            w_neg = w_res[31];
         end
         c_op_slti: begin
            w_neg = $signed(w_rs_val) < $signed(w_simm);
            w_res = {31'd0, w_neg};
         end
         c_op_sltiu: begin
            w_neg = w_rs_val < w_simm;
            w_res = {31'd0, w_neg};
         end
         c_op_andi: w_res = w_rs_val & w_zimm;
         c_op_ori:  w_res = w_rs_val | w_zimm;
         c_op_xori: w_res = w_rs_val ^ w_zimm;
         c_op_beq, c_op_bne: begin
            w_res = w_rs_val - w_rt_val;
            w_neg = w_res[31];
         end
         default: w_valid = 1'b0;
      endcase
   end

   always_comb begin
      o_result = '0;
      o_flags  = '0;
      if (w_valid) begin
         o_result              = w_res;
         o_flags[c_flag_zero]  = (w_res == '0);
         o_flags[c_flag_neg]   = w_neg;
         o_flags[c_flag_ovf]   = w_ovf;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu.sv
//------------------------------------------------------------------------------
// Module   : alu
// Purpose  : Registered MIPS-subset ALU: combinational core plus output
//            register with synchronous reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu
   import alu_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   alu_if.slave      bus
);

   logic [c_data_w-1:0] result_d;
   logic [c_data_w-1:0] result_q;
   logic [c_flag_w-1:0] flags_d;
   logic [c_flag_w-1:0] flags_q;

   alu_core u_core (
      .i_instruction (bus.instruction),
      .i_reg_a       (bus.regA),
      .i_reg_b       (bus.regB),
      .o_result      (result_d),
      .o_flags       (flags_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign bus.result = result_q;
   assign bus.flags  = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
//------------------------------------------------------------------------------
// Module   : tb_alu
// Purpose  : Scoreboard bench for alu: directed vectors plus randomized
//            instructions checked against a wide-arithmetic reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] r;
      logic [2:0]  f;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   total;
   int   bad;
   bit   stim_done;

   alu_if bus ();

   alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-precision signed arithmetic decides overflow.
   function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic [2:0] f);
      logic [31:0] s, t, sext;
      longint      ss, ts, ims, full;
      logic        ok, neg, ovf;
      int          sh;
      s    = (ins[25:21] == 5'd0) ? a : b;
      t    = (ins[20:16] == 5'd0) ? a : b;
      sext = {{16{ins[15]}}, ins[15:0]};
      ss   = $signed(s);
      ts   = $signed(t);
      ims  = $signed(sext);
      ok = 1'b1; neg = 1'b0; ovf = 1'b0; r = 32'd0; full = 0;
      if (ins[31:26] == 6'd0) begin
         sh = (ins[5:0] inside {6'o04, 6'o06, 6'o07}) ? int'(s[4:0]) : int'(ins[10:6]);
         case (ins[5:0])
            6'h20, 6'h21: begin full = ss + ts; r = full[31:0]; neg = r[31];
                             ovf = (ins[5:0] == 6'h20) && (full > 64'sd2147483647 || full < -64'sd2147483648); end
            6'h22, 6'h23: begin full = ss - ts; r = full[31:0]; neg = r[31];
                             ovf = (ins[5:0] == 6'h22) && (full > 64'sd2147483647 || full < -64'sd2147483648); end
            6'h24: r = s & t;
            6'h25: r = s | t;
            6'h26: r = s ^ t;
            6'h27: r = ~(s | t);
            6'h2A: begin neg = ss < ts; r = {31'd0, neg}; end
            6'h2B: begin neg = s < t; r = {31'd0, neg}; end
            6'h00, 6'h04: r = t << sh;
            6'h02, 6'h06: r = t >> sh;
            6'h03, 6'h07: begin full = ts >>> sh; r = full[31:0]; end
            default: ok = 1'b0;
         endcase
      end else begin
         case (ins[31:26])
            6'h08, 6'h09, 6'h23, 6'h2B: begin full = ss + ims; r = full[31:0]; neg = r[31];
                             ovf = (ins[31:26] == 6'h08) && (full > 64'sd2147483647 || full < -64'sd2147483648); end
            6'h0A: begin neg = ss < ims; r = {31'd0, neg}; end
            6'h0B: begin neg = s < sext; r = {31'd0, neg}; end
            6'h0C: r = s & {16'd0, ins[15:0]};
            6'h0D: r = s | {16'd0, ins[15:0]};
            6'h0E: r = s ^ {16'd0, ins[15:0]};
            6'h04, 6'h05: begin full = ss - ts; r = full[31:0]; neg = r[31]; end
            default: ok = 1'b0;
         endcase
      end
      if (!ok) begin
         r = 32'd0;
         f = 3'b000;
      end else begin
         f = {(r == 32'd0), neg, ovf};
      end
   endfunction

   task automatic drive(input logic rst_v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef);
      exp_t e;
      @(negedge clk);
      rst             = rst_v;
      bus.instruction = ins;
      bus.regA        = a;
      bus.regB        = b;
      e.instr = ins;
      e.r     = er;
      e.f     = ef;
      exp_q.push_back(e);
   endtask

   task automatic drive_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic [2:0]  ef;
      ref_model(ins, a, b, er, ef);
      drive(1'b0, ins, a, b, er, ef);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [4:0] pick_reg();
      return ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
   endfunction

   // Monitor: one scoreboard entry per clock edge following a drive.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (bus.result !== e.r) begin
            bad++;
            $display("FAIL result: instr=%h actual=%h required=%h", e.instr, bus.result, e.r);
         end
         total++;
         if (bus.flags !== e.f) begin
            bad++;
            $display("FAIL flags: instr=%h actual=%b required=%b", e.instr, bus.flags, e.f);
         end
      end
   end

   initial begin
      logic [5:0]  fn_tab [16];
      logic [5:0]  op_tab [12];
      logic [31:0] ins;
      int          k;
      total = 0;
      bad   = 0;
      stim_done = 1'b0;
      rst = 1'b1;
      bus.instruction = '0;
      bus.regA = '0;
      bus.regB = '0;
      fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      op_tab = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                 6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};

      drive(1'b1, 32'h0001_4020, 32'd4, 32'd5, 32'd0, 3'b000);
      drive(1'b0, 32'h0001_4020, 32'd4, 32'd5, 32'd9, 3'b000);
      drive(1'b0, 32'h0000_4020, -32'sd4, 32'd5, 32'hFFFF_FFF8, 3'b010);
      drive(1'b0, 32'h0001_4020, 32'd2147483640, 32'd2147483641, 32'hFFFF_FFF1, 3'b011);
      drive(1'b0, 32'h0001_4020, -32'sd2147483640, -32'sd2147483641, 32'h0000_000F, 3'b001);
      drive(1'b0, 32'h0001_4020, -32'sd10, 32'd10, 32'h0000_0000, 3'b100);
      drive(1'b0, 32'h2020_FF9C, 32'd0, 32'd19, -32'sd81, 3'b010);
      drive(1'b0, 32'h2020_FF9C, 32'd0, -32'sd2147483640, 32'h7FFF_FFA4, 3'b001);
      drive(1'b0, 32'h2000_0064, 32'd2147483640, 32'd0, 32'h8000_005C, 3'b011);
      drive(1'b0, 32'h0001_4021, 32'd2147483640, 32'd2147483641, 32'hFFFF_FFF1, 3'b010);
      drive(1'b0, 32'h2400_0064, 32'd200, 32'd0, 32'd300, 3'b000);
      drive(1'b0, 32'h0001_402B, 32'd1, 32'hFFFF_FFFF, 32'd1, 3'b010);
      drive(1'b0, 32'h0001_4103, 32'd0, 32'h8000_0000, 32'hF800_0000, 3'b000);
      drive(1'b0, 32'h0001_4022, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b001);
      drive(1'b0, 32'hFC00_0000, 32'd5, 32'd6, 32'd0, 3'b000);
      drive(1'b1, 32'h0001_4020, 32'd4, 32'd5, 32'd0, 3'b000);
      drive(1'b0, 32'h0001_4023, 32'd7, 32'd7, 32'd0, 3'b100);

      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 31);
         if (k < 16)
            ins = {6'd0, pick_reg(), pick_reg(), 5'($urandom), 5'($urandom), fn_tab[k]};
         else if (k < 28)
            ins = {op_tab[k-16], pick_reg(), pick_reg(), 16'($urandom)};
         else
            ins = $urandom;
         if ($urandom_range(0, 24) == 0)
            drive(1'b1, ins, pick_val(), pick_val(), 32'd0, 3'b000);
         else
            drive_model(ins, pick_val(), pick_val());
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(negedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
